tt_serial_rx_byte: RTL

//   Receive end of the single-wire async serial link between two TinyTapeout user modules.
//   - Samples one UART-style line on io_in, deserialises 7-bit LSB-first frames.
//   - Presents the last good character on io_out with a one-cycle valid strobe.
//   - Same 8-in/8-out tile footprint as the other user modules; clock and reset taken from io_in.

---
 rtl/tt_serial_rx_byte_if.sv | 9 +
 rtl/tt_serial_rx_byte.sv | 139 +++++++++++++
 2 files changed

// File: rtl/tt_serial_rx_byte_if.sv
// Tile pin bundle for tt_serial_rx_byte: 8 input pins (clock, reset, serial line, spares)
// and 8 output pins (received character plus valid strobe).
interface tt_serial_rx_byte_if;
  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);
endinterface

// File: rtl/tt_serial_rx_byte.sv
// UART-style receiver for the TinyTapeout tile link: 2-flop synchroniser, mid-bit sampling,
// LSB-first frames. Define TT_SERIAL_RX_PARITY_EN to add an even-parity bit after the data.
module tt_serial_rx_byte #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_BITS    = 7
) (
  tt_serial_rx_byte_if.slave tile
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]     CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]           BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [DATA_BITS-1:0] SHIFT_MSB = DATA_BITS'(1) << (DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TT_SERIAL_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  logic clk;
  logic rst_n;
  logic rxd;
  logic unused_io;

  assign clk       = tile.io_in[0];
  assign rst_n     = tile.io_in[1];
  assign rxd       = tile.io_in[2];
  assign unused_io = ^tile.io_in[7:3];

  logic                 rx_p0;
  logic                 rxs;
  state_t               state;
  logic [CNT_W-1:0]     clk_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [6:0]           data_q;
  logic                 valid_q;
  logic                 bit_tick;
  logic                 shift_en;

  assign bit_tick = (clk_cnt == CNT_LAST);
  assign shift_en = (state == DATA) && bit_tick;

  assign tile.io_out = {valid_q, data_q};

  // Deserialiser: new bit enters at the top so the first (LSB) bit ends up at bit 0.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      shreg <= (shreg >> 1) | (rxs ? SHIFT_MSB : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0   <= 1'b1;
      rxs     <= 1'b1;
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      rx_p0   <= rxd;
      rxs     <= rx_p0;
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state   <= START;
            clk_cnt <= '0;
          end
        end
        START: begin
          if (clk_cnt == CNT_HALF) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef TT_SERIAL_RX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`ifdef TT_SERIAL_RX_PARITY_EN
        PARITY: begin
          // Even parity: the parity bit equals the XOR of the data bits.
          if (bit_tick) begin
            clk_cnt <= '0;
            state   <= (rxs == ^shreg) ? STOP : BREAK;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            if (rxs) begin
              data_q  <= 7'(shreg);
              valid_q <= 1'b1;
              state   <= IDLE;
            end else begin
              state   <= BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
